// File: rtl/uart_tx_arbiter.sv
// Two-requester, packet-granular round-robin arbiter in front of one UART transmitter.
// Bytes are paced by the transmitter's done pulse; a watchdog reclaims the link from a stalled owner.
module uart_tx_arbiter #(
  parameter logic [23:0] TIMEOUT = 24'd5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       ip_flag,
  output logic [7:0] ip_data,
  input  logic       tx_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        rr_q, rr_d;
  logic [23:0] timer_q, timer_d;
  logic        last_q, last_d;
  logic [7:0]  ip_data_q, ip_data_d;
  logic        ip_flag_q, ip_flag_d;
  logic        err_q, err_d;
  logic        hs;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      rr_q      <= 1'b0;
      timer_q   <= 24'd0;
      last_q    <= 1'b0;
      ip_data_q <= 8'd0;
      ip_flag_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      ip_data_q <= ip_data_d;
      ip_flag_q <= ip_flag_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    timer_d   = timer_q;
    last_d    = last_q;
    ip_data_d = ip_data_q;
    ip_flag_d = 1'b0;
    err_d     = 1'b0;
    hs        = (state_q == SEND) &&
                ((grant_q[0] && req0_valid) || (grant_q[1] && req1_valid));
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          state_d = SEND;
          timer_d = 24'd0;
          if (req0_valid && req1_valid) grant_d = rr_q ? 2'b10 : 2'b01;
          else                          grant_d = req0_valid ? 2'b01 : 2'b10;
        end
      end
      SEND: begin
        if (hs) begin
          ip_data_d = grant_q[1] ? req1_data : req0_data;
          last_d    = grant_q[1] ? req1_last : req0_last;
          ip_flag_d = 1'b1;
          state_d   = WAIT;
        end else if (timer_q >= TIMEOUT - 24'd1) begin
          // Stalled owner: the other requester gets priority next round.
          err_d   = 1'b1;
          grant_d = 2'b00;
          rr_d    = grant_q[0];
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (last_q) begin
            grant_d = 2'b00;
            rr_d    = grant_q[0];
            state_d = IDLE;
          end else begin
            timer_d = 24'd0;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == SEND) && grant_q[0];
    req1_ready = (state_q == SEND) && grant_q[1];
    busy       = (state_q != IDLE);
  end

  assign grant       = grant_q;
  assign ip_flag     = ip_flag_q;
  assign ip_data     = ip_data_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected bytes/owners,
// a negedge monitor pops and checks them on every ip_flag; a small transmitter model answers ip_flag.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic [7:0] req0_data;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req1_data;
  logic       ip_flag;
  logic [7:0] ip_data;
  logic       tx_done, tx_auto_done, tx_force;
  logic [1:0] grant;
  logic       busy, timeout_err;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gnt;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   flag_cnt   = 0;
  int   err_cnt    = 0;
  int   tx_cnt     = 0;
  bit   mon_en     = 0;
  logic prev_flag  = 1'b0;

  always #5 clk = ~clk;
  assign tx_done = tx_auto_done | tx_force;

  uart_tx_arbiter #(.TIMEOUT(24'd20)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .ip_flag(ip_flag), .ip_data(ip_data), .tx_done(tx_done),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fail_bound(input string nm);
    compared++;
    mismatched++;
    $display("FAIL %s: wait bound expired before the expected event", nm);
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data = d;
    e.gnt  = g;
    exp_q.push_back(e);
  endtask

  // Transmitter model: done pulse 10 cycles after each start pulse; cleared by reset.
  initial begin
    tx_auto_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_auto_done = 1'b0;
      if (!rst_n) tx_cnt = 0;
      else begin
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_auto_done = 1'b1;
        end
        if (ip_flag) tx_cnt = 10;
      end
    end
  end

  // Monitor: every start pulse must match the next expected byte and owner.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (timeout_err) err_cnt++;
        if (ip_flag) begin
          flag_cnt++;
          chk("ip_flag_single_cycle", 32'(prev_flag), 0);
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_ip_flag: got ip_data 0x%0h, expected no start pulse", ip_data);
          end else begin
            e = exp_q.pop_front();
            chk("ip_data", 32'(ip_data), 32'(e.data));
            chk("grant_at_ip_flag", 32'(grant), 32'(e.gnt));
          end
        end
        prev_flag = ip_flag;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge with valid dropped.
  task automatic send(input int id, input logic [7:0] d, input logic l);
    int n = 0;
    if (id == 0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    else         begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    while (!((id == 0) ? req0_ready : req1_ready)) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        fail_bound("send_handshake");
        break;
      end
    end
    @(negedge clk);
    if (id == 0) req0_valid = 1'b0;
    else         req1_valid = 1'b0;
  endtask

  task automatic wait_txdone();
    int n = 0;
    while (!tx_done) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        fail_bound("wait_tx_done");
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        fail_bound("wait_idle");
        return;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    int f0, e0, j;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    tx_force = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ip_flag", 32'(ip_flag), 0);
    chk("rst_ip_data", 32'(ip_data), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_ready", 32'({req1_ready, req0_ready}), 0);
    mon_en = 1;

    // Single requester, three-byte packet.
    f0 = flag_cnt;
    push(8'hA1, 2'b01); push(8'hA2, 2'b01); push(8'hA3, 2'b01);
    send(0, 8'hA1, 1'b0);
    send(0, 8'hA2, 1'b0);
    send(0, 8'hA3, 1'b1);
    wait_txdone();
    @(negedge clk);
    chk("t1_grant_released", 32'(grant), 0);
    chk("t1_busy_released", 32'(busy), 0);
    chk("t1_flag_count", 32'(flag_cnt - f0), 3);

    // Both valid from reset: req0 first, then req1; again after that req0 wins.
    do_reset();
    push(8'h11, 2'b01); push(8'h12, 2'b01); push(8'h21, 2'b10); push(8'h22, 2'b10);
    fork
      begin send(0, 8'h11, 1'b0); send(0, 8'h12, 1'b1); end
      begin send(1, 8'h21, 1'b0); send(1, 8'h22, 1'b1); end
    join
    wait_idle();
    push(8'h13, 2'b01); push(8'h14, 2'b01); push(8'h23, 2'b10); push(8'h24, 2'b10);
    fork
      begin send(0, 8'h13, 1'b0); send(0, 8'h14, 1'b1); end
      begin send(1, 8'h23, 1'b0); send(1, 8'h24, 1'b1); end
    join
    wait_idle();
    chk("t2_grant_idle", 32'(grant), 0);

    // Watchdog: req1 stalls after one byte, req0 pending.
    e0 = err_cnt;
    push(8'h55, 2'b10); push(8'h66, 2'b01);
    send(1, 8'h55, 1'b0);
    fork
      send(0, 8'h66, 1'b1);
      begin
        wait_txdone();
        j = 0;
        while (!timeout_err && j < 40) begin
          @(negedge clk);
          j++;
        end
        chk("t3_timeout_delay", 32'(j), 21);
        chk("t3_grant_after_timeout", 32'(grant), 0);
        chk("t3_busy_after_timeout", 32'(busy), 0);
        @(negedge clk);
        chk("t3_timeout_err_cleared", 32'(timeout_err), 0);
        chk("t3_req0_granted", 32'(grant), 1);
      end
    join
    wait_idle();
    chk("t3_timeout_pulses", 32'(err_cnt - e0), 1);

    // Single-byte packet from req0 with req1 waiting.
    do_reset();
    push(8'h7E, 2'b01); push(8'h31, 2'b10);
    fork
      send(0, 8'h7E, 1'b1);
      send(1, 8'h31, 1'b1);
      begin
        wait_txdone();
        @(negedge clk);
        chk("t4_idle_gap", 32'(grant), 0);
        @(negedge clk);
        chk("t4_req1_grant", 32'(grant), 2);
      end
    join
    wait_idle();

    // Reset during WAIT, then spurious tx_done in IDLE, then fresh arbitration.
    push(8'h41, 2'b01); push(8'h42, 2'b10);
    send(0, 8'h41, 1'b1);
    wait_idle();
    send(1, 8'h42, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_grant", 32'(grant), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_ip_flag", 32'(ip_flag), 0);
    chk("t5_ip_data", 32'(ip_data), 0);
    chk("t5_timeout_err", 32'(timeout_err), 0);
    tx_force = 1'b1;
    @(negedge clk);
    tx_force = 1'b0;
    @(negedge clk);
    chk("t5_idle_after_spurious", 32'({busy, grant}), 0);
    push(8'h43, 2'b01); push(8'h44, 2'b10);
    fork
      send(0, 8'h43, 1'b1);
      send(1, 8'h44, 1'b1);
    join
    wait_idle();

    // Spurious tx_done while the owner is in SEND with valid low.
    push(8'h50, 2'b01); push(8'h51, 2'b01);
    send(0, 8'h50, 1'b0);
    wait_txdone();
    @(negedge clk);
    tx_force = 1'b1;
    @(negedge clk);
    tx_force = 1'b0;
    chk("t6_busy", 32'(busy), 1);
    chk("t6_grant", 32'(grant), 1);
    chk("t6_ready_held", 32'(req0_ready), 1);
    send(0, 8'h51, 1'b1);
    wait_idle();

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (8-bit byte + one-cycle start pulse, byte-done pulse back) between two packet-oriented byte requesters.
- Typical requesters: the RX-FIFO loopback controller (req0) and the SPI-flash readback/status path (req1).
- Arbitrates round-robin at packet boundaries, paces bytes to the transmitter's done pulse, and reclaims the link from a stalled owner via a watchdog.

Parameters:
TIMEOUT, 24'd5_000_000, max idle cycles between owner's bytes inside a packet before forced release (100 ms at 50 MHz); must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
req0_valid  in  1  requester 0 has a byte
req0_data  in  8  requester 0 byte
req0_last  in  1  byte is last of requester 0 packet
req0_ready  out  1  requester 0 byte accepted this cycle (when valid)
req1_valid  in  1  requester 1 has a byte
req1_data  in  8  requester 1 byte
req1_last  in  1  byte is last of requester 1 packet
req1_ready  out  1  requester 1 byte accepted this cycle (when valid)
ip_flag  out  1  one-cycle start pulse to transmitter
ip_data  out  8  byte to transmitter, stable from ip_flag until tx_done
tx_done  in  1  one-cycle pulse from transmitter: byte fully shifted out
grant  out  2  one-hot current owner; 2'b00 when idle
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE, grant=0, ip_flag=0, ip_data=0, timeout_err=0, busy=0, rr_ptr=0, timer=0, last latch=0. Reset mid-byte aborts silently; transmitter is reset by the same rst_n.
- reqN_ready is combinational: 1 iff state==SEND and grant[N]=1; a byte transfers when reqN_valid & reqN_ready at a clock edge.
- States:
  IDLE: if exactly one valid -> that requester becomes owner. If both valid -> requester rr_ptr becomes owner. Grant is registered; next state SEND; timer cleared. No valid -> stay.
  SEND: on owner handshake, capture data into ip_data and last into last latch, set ip_flag=1 for the next cycle only, go WAIT. Otherwise timer increments. If timer reaches TIMEOUT-1 with no handshake: timeout_err=1 next cycle, grant=0, rr_ptr=other requester, go IDLE.
  WAIT: hold ip_data. On tx_done: if last latch=1 -> grant=0, rr_ptr=other than finished owner, go IDLE. Else -> go SEND, timer cleared.
- Latency: valid in IDLE -> grant at +1 cycle, ready at +1. Handshake at cycle N -> ip_flag high in cycle N+1 only. tx_done at cycle M -> ready again at M+1 (non-last), or IDLE at M+1 (last) with earliest new grant at M+2.
- The non-owner's valid is ignored until the owner releases; no preemption mid-packet.
- The first byte of a packet is not subject to the watchdog: the owner is only selected while valid=1.
- tx_done outside WAIT is ignored. The watchdog is inactive in WAIT; the transmitter is trusted to finish.
- Owner valid dropping between bytes is legal; only the timer governs.
- A single-byte packet (last on first byte) is legal.
- Timer width: 24 bits, saturating compare at TIMEOUT-1.

Test Plan:
- Only req0, packet A1,A2,A3 (last on A3), tx_done 10 cycles after each ip_flag -> ip_data sequence A1,A2,A3; exactly 3 ip_flag pulses; grant 2'b01 throughout; grant 2'b00 and busy 0 the cycle after the third tx_done.
- req0 and req1 both valid from reset, each a 2-byte packet -> req0 served first (rr_ptr=0), then req1. Then both request again -> req0 wins again (rr_ptr back to 0 after req1). Grant never changes mid-packet.
- req1 sends 0x55 (not last), then holds valid=0; TIMEOUT=20 -> timeout_err pulses exactly once, 20 cycles after entering SEND; grant returns to 0; a pending req0 is granted next.
- req0 single byte 0x7E with last=1 while req1 is valid -> 0x7E sent; req1 granted exactly 2 cycles after tx_done.
- rst_n low for 1 cycle while in WAIT -> all outputs 0 the next cycle. A tx_done arriving after reset produces no state change; a new request is arbitrated from rr_ptr=0.
- Spurious tx_done pulses in IDLE and in SEND -> no ip_flag, no state change.
